// File: rtl/cnn_pkg.sv
// -----------------------------------------------------------------------------
// cnn_pkg
// Shared constants for the MNIST CNN layer sequencer: sequencer state codes,
// the state enum built on those codes, layer mode encodings and the default
// picture-memory address width.
// -----------------------------------------------------------------------------
package cnn_pkg;

    localparam int DEF_ADDR_BIT = 10;

    // State codes are visible to software through err_stage.
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CONV0 = 3'd1;
    localparam logic [2:0] ST_POOL0 = 3'd2;
    localparam logic [2:0] ST_CONV1 = 3'd3;
    localparam logic [2:0] ST_POOL1 = 3'd4;
    localparam logic [2:0] ST_FC    = 3'd5;
    localparam logic [2:0] ST_DONE  = 3'd6;
    localparam logic [2:0] ST_ERR   = 3'd7;

    // conv: 0 = 28->24, 1 = 12->8 ; pool: 0 = 24->12, 1 = 8->4
    localparam logic CONV_L0 = 1'b0;
    localparam logic CONV_L1 = 1'b1;
    localparam logic POOL_L0 = 1'b0;
    localparam logic POOL_L1 = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_CONV0 = ST_CONV0,
        S_POOL0 = ST_POOL0,
        S_CONV1 = ST_CONV1,
        S_POOL1 = ST_POOL1,
        S_FC    = ST_FC,
        S_DONE  = ST_DONE,
        S_ERR   = ST_ERR
    } state_t;

endpackage

// File: rtl/cnn_layer_sequencer_stage_watchdog.sv
// -----------------------------------------------------------------------------
// stage_watchdog
// Per-stage cycle counter. Counts while en is high, returns to zero on clr,
// and flags timeout while enabled and the count equals WDOG_LIMIT.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear (has priority over en)
//   en         : count enable (sequencer is in a stage state)
//   timeout    : count reached WDOG_LIMIT during an enabled cycle
// -----------------------------------------------------------------------------
module stage_watchdog #(
    parameter int                  WDOG_BIT   = 20,
    parameter logic [WDOG_BIT-1:0] WDOG_LIMIT = 20'd65535
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    logic [WDOG_BIT-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign timeout = en && (cnt == WDOG_LIMIT);

endmodule

// File: rtl/cnn_layer_sequencer.sv
// -----------------------------------------------------------------------------
// cnn_layer_sequencer
// Runs the CNN layers in order conv0 -> pool0 -> conv1 -> pool1 -> fc on a CPU
// start, handing each stage scheduler a start pulse plus mode and waiting for
// its done pulse. Owns the picture-memory port mux and traps hung stages with
// a per-stage watchdog.
//   clk, rst_n                 : clock, async active-low reset
//   start, err_clr             : CPU run request / error clear
//   cpu_mem_*                  : CPU memory request, cpu_mem_gnt = CPU owns port
//   conv_*, pool_*, fc_*       : scheduler handshakes and memory requests
//   mem_addr, mem_we           : muxed picture-memory port
//   busy, done, err, err_stage : status (err_stage = state code that timed out)
//
// state | meaning
// IDLE  | CPU owns memory, waiting for start
// CONV0 | conv layer 0 (28->24)
// POOL0 | maxpool layer 0 (24->12)
// CONV1 | conv layer 1 (12->8)
// POOL1 | maxpool layer 1 (8->4)
// FC    | fully-connected layer (memory read only)
// DONE  | one-cycle completion, back to IDLE
// ERR   | watchdog tripped, held until err_clr
// -----------------------------------------------------------------------------
module cnn_layer_sequencer
    import cnn_pkg::*;
#(
    parameter int                  ADDR_BIT   = DEF_ADDR_BIT,
    parameter int                  WDOG_BIT   = 20,
    parameter logic [WDOG_BIT-1:0] WDOG_LIMIT = 20'd65535
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                err_clr,
    input  logic [ADDR_BIT-1:0] cpu_mem_addr,
    input  logic                cpu_mem_we,
    output logic                cpu_mem_gnt,
    output logic                conv_start,
    output logic                conv_mode,
    input  logic                conv_done,
    input  logic [ADDR_BIT-1:0] conv_mem_addr,
    input  logic                conv_mem_we,
    output logic                pool_start,
    output logic                pool_mode,
    input  logic                pool_done,
    input  logic [ADDR_BIT-1:0] pool_mem_addr,
    input  logic                pool_mem_we,
    output logic                fc_start,
    input  logic                fc_done,
    input  logic [ADDR_BIT-1:0] fc_mem_addr,
    output logic [ADDR_BIT-1:0] mem_addr,
    output logic                mem_we,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [2:0]          err_stage
);

    state_t state;
    logic   in_stage;
    logic   stage_done;
    logic   timeout;

    // Only the done of the scheduler owning the current stage counts.
    always_comb begin
        in_stage   = 1'b0;
        stage_done = 1'b0;
        case (state)
            S_CONV0, S_CONV1: begin in_stage = 1'b1; stage_done = conv_done; end
            S_POOL0, S_POOL1: begin in_stage = 1'b1; stage_done = pool_done; end
            S_FC:             begin in_stage = 1'b1; stage_done = fc_done;   end
            default:          ;
        endcase
    end

    // Clearing on the done cycle makes the next stage start counting from 0.
    stage_watchdog #(
        .WDOG_BIT   (WDOG_BIT),
        .WDOG_LIMIT (WDOG_LIMIT)
    ) u_wdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (!in_stage || stage_done),
        .en      (in_stage),
        .timeout (timeout)
    );

    always_comb begin
        mem_addr    = cpu_mem_addr;
        mem_we      = cpu_mem_we;
        cpu_mem_gnt = 1'b1;
        case (state)
            S_CONV0, S_CONV1: begin
                mem_addr = conv_mem_addr; mem_we = conv_mem_we; cpu_mem_gnt = 1'b0;
            end
            S_POOL0, S_POOL1: begin
                mem_addr = pool_mem_addr; mem_we = pool_mem_we; cpu_mem_gnt = 1'b0;
            end
            S_FC: begin
                mem_addr = fc_mem_addr; mem_we = 1'b0; cpu_mem_gnt = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            conv_start <= 1'b0;
            pool_start <= 1'b0;
            fc_start   <= 1'b0;
            conv_mode  <= CONV_L0;
            pool_mode  <= POOL_L0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            err_stage  <= ST_IDLE;
        end else begin
            conv_start <= 1'b0;
            pool_start <= 1'b0;
            fc_start   <= 1'b0;
            done       <= 1'b0;
            // A done in the limit cycle still advances the stage.
            if (timeout && !stage_done) begin
                state     <= S_ERR;
                err       <= 1'b1;
                err_stage <= state;
                busy      <= 1'b0;
                conv_mode <= CONV_L0;
                pool_mode <= POOL_L0;
            end else begin
                case (state)
                    S_IDLE: if (start) begin
                        state      <= S_CONV0;
                        conv_start <= 1'b1;
                        conv_mode  <= CONV_L0;
                        busy       <= 1'b1;
                    end
                    S_CONV0: if (conv_done) begin
                        state      <= S_POOL0;
                        pool_start <= 1'b1;
                        pool_mode  <= POOL_L0;
                    end
                    S_POOL0: if (pool_done) begin
                        state      <= S_CONV1;
                        conv_start <= 1'b1;
                        conv_mode  <= CONV_L1;
                    end
                    S_CONV1: if (conv_done) begin
                        state      <= S_POOL1;
                        pool_start <= 1'b1;
                        pool_mode  <= POOL_L1;
                        conv_mode  <= CONV_L0;
                    end
                    S_POOL1: if (pool_done) begin
                        state     <= S_FC;
                        fc_start  <= 1'b1;
                        pool_mode <= POOL_L0;
                    end
                    S_FC: if (fc_done) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                    end
                    S_DONE: state <= S_IDLE;
                    S_ERR: if (err_clr) begin
                        state     <= S_IDLE;
                        err       <= 1'b0;
                        err_stage <= ST_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// -----------------------------------------------------------------------------
// tb_cnn_layer_sequencer
// Drives the sequencer with scheduler models whose done latency is chosen per
// stage, random memory traffic and optional stray done / start pulses, and
// compares every output each cycle against a stage-list reference model.
// -----------------------------------------------------------------------------
module tb_cnn_layer_sequencer;

    localparam int AB    = 10;
    localparam int LIMIT = 50;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0, err_clr = 1'b0;
    logic [AB-1:0] cpu_mem_addr = '0, conv_mem_addr = '0, pool_mem_addr = '0, fc_mem_addr = '0;
    logic          cpu_mem_we = 1'b0, conv_mem_we = 1'b0, pool_mem_we = 1'b0;
    logic          conv_done = 1'b0, pool_done = 1'b0, fc_done = 1'b0;
    logic          cpu_mem_gnt, conv_start, conv_mode, pool_start, pool_mode, fc_start;
    logic [AB-1:0] mem_addr;
    logic          mem_we, busy, done, err;
    logic [2:0]    err_stage;

    always #5 clk = ~clk;

    cnn_layer_sequencer #(
        .ADDR_BIT(AB), .WDOG_BIT(20), .WDOG_LIMIT(20'd50)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .err_clr(err_clr),
        .cpu_mem_addr(cpu_mem_addr), .cpu_mem_we(cpu_mem_we), .cpu_mem_gnt(cpu_mem_gnt),
        .conv_start(conv_start), .conv_mode(conv_mode), .conv_done(conv_done),
        .conv_mem_addr(conv_mem_addr), .conv_mem_we(conv_mem_we),
        .pool_start(pool_start), .pool_mode(pool_mode), .pool_done(pool_done),
        .pool_mem_addr(pool_mem_addr), .pool_mem_we(pool_mem_we),
        .fc_start(fc_start), .fc_done(fc_done), .fc_mem_addr(fc_mem_addr),
        .mem_addr(mem_addr), .mem_we(mem_we), .busy(busy), .done(done),
        .err(err), .err_stage(err_stage)
    );

    int n_cmp = 0, n_bad = 0, cyc = 0;

    // Reference model: m_st holds the state code (0 idle, 1..5 the five
    // stages in run order, 6 done, 7 err); m_age = cycles since stage entry.
    int m_st = 0, m_age = 0, m_err_stage = 0;
    bit m_err = 1'b0;
    int lat [8];                       // done latency per stage code, -1 = hang
    bit strays = 0, rnd_start = 0, fixed_addr = 0, start_req = 0, clr_req = 0;

    // 1 = conv scheduler, 2 = pool scheduler, 3 = fc scheduler, 0 = no stage
    function automatic int kind(input int s);
        case (s)
            1, 3:    return 1;
            2, 4:    return 2;
            5:       return 3;
            default: return 0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_st = 0; m_age = 0; m_err = 1'b0; m_err_stage = 0;
    endtask

    task automatic drive();
        int  k;
        bit  act;
        cpu_mem_addr  = 10'($urandom);
        conv_mem_addr = 10'($urandom);
        pool_mem_addr = 10'($urandom);
        fc_mem_addr   = 10'($urandom);
        cpu_mem_we    = 1'($urandom_range(1));
        conv_mem_we   = 1'($urandom_range(1));
        pool_mem_we   = 1'($urandom_range(1));
        if (fixed_addr) begin
            cpu_mem_addr = 10'h3FF; conv_mem_addr = 10'h123; conv_mem_we = 1'b1;
        end
        start     = start_req;
        err_clr   = clr_req;
        conv_done = strays && ($urandom_range(3) == 0);
        pool_done = strays && ($urandom_range(3) == 0);
        fc_done   = strays && ($urandom_range(3) == 0);
        k   = kind(m_st);
        act = (k != 0) && (lat[m_st] >= 0) && (m_age == lat[m_st]);
        case (k)
            1: conv_done = act;
            2: pool_done = act;
            3: fc_done   = act;
            default: ;
        endcase
    endtask

    task automatic model_step();
        int k;
        bit d;
        k = kind(m_st);
        d = (k == 1) ? conv_done : (k == 2) ? pool_done : (k == 3) ? fc_done : 1'b0;
        if (m_st == 0) begin
            if (start) begin m_st = 1; m_age = 0; end
        end else if (k != 0) begin
            if (d) begin
                m_st = m_st + 1; m_age = 0;
            end else if (m_age == LIMIT) begin
                m_err = 1'b1; m_err_stage = m_st; m_st = 7;
            end else begin
                m_age++;
            end
        end else if (m_st == 6) begin
            m_st = 0;
        end else if (err_clr) begin
            m_st = 0; m_err = 1'b0; m_err_stage = 0;
        end
    endtask

    task automatic check_all();
        int            k;
        logic [AB-1:0] e_addr;
        bit            e_we, e_gnt;
        k = kind(m_st);
        check("busy",       32'(busy),       32'(k != 0));
        check("done",       32'(done),       32'(m_st == 6));
        check("err",        32'(err),        32'(m_err));
        if (m_err) check("err_stage", 32'(err_stage), 32'(m_err_stage));
        check("conv_start", 32'(conv_start), 32'(k == 1 && m_age == 0));
        check("pool_start", 32'(pool_start), 32'(k == 2 && m_age == 0));
        check("fc_start",   32'(fc_start),   32'(k == 3 && m_age == 0));
        check("conv_mode",  32'(conv_mode),  32'(m_st == 3));
        check("pool_mode",  32'(pool_mode),  32'(m_st == 4));
        case (k)
            1:       begin e_addr = conv_mem_addr; e_we = conv_mem_we; e_gnt = 1'b0; end
            2:       begin e_addr = pool_mem_addr; e_we = pool_mem_we; e_gnt = 1'b0; end
            3:       begin e_addr = fc_mem_addr;   e_we = 1'b0;        e_gnt = 1'b0; end
            default: begin e_addr = cpu_mem_addr;  e_we = cpu_mem_we;  e_gnt = 1'b1; end
        endcase
        check("cpu_mem_gnt", 32'(cpu_mem_gnt), 32'(e_gnt));
        check("mem_addr",    32'(mem_addr),    32'(e_addr));
        check("mem_we",      32'(mem_we),      32'(e_we));
    endtask

    task automatic run_cycle();
        drive();
        if (rst_n) model_step();
        @(posedge clk);
        #1;
        cyc++;
        check_all();
    endtask

    // One full network run from IDLE until the model is back in IDLE or ERR.
    task automatic run_seq(input int budget, output int t_start, output int t_done);
        int n;
        bit started;
        n = 0; started = 0; t_start = -1; t_done = -1;
        while (n < budget) begin
            if (m_st == 0 && !started) begin
                start_req = 1'b1;
                if (t_start < 0) t_start = cyc;
            end else begin
                start_req = rnd_start && ($urandom_range(2) == 0);
            end
            run_cycle();
            n++;
            if (done && t_done < 0) t_done = cyc;
            if (m_st != 0) started = 1;
            if (started && (m_st == 0 || m_st == 7)) break;
        end
        start_req = 1'b0;
        check("seq_bound", 32'(n < budget), 32'd1);
    endtask

    initial begin
        int ts, td, tps, te, n;
        for (int i = 0; i < 8; i++) lat[i] = 10;

        // Reset values
        model_reset();
        repeat (3) run_cycle();
        check("rst_err_stage", 32'(err_stage), 32'd0);
        rst_n = 1'b1;
        repeat (2) run_cycle();

        // Nominal run, 10-cycle schedulers, fixed mux pattern in CONV0.
        // Each stage lasts latency+1 cycles, conv_start lands one cycle after
        // start, so done appears 1 + 5*11 cycles after start was driven.
        fixed_addr = 1;
        run_seq(200, ts, td);
        check("done_latency", 32'(td - ts), 32'(1 + 5 * 11));
        run_cycle();
        check("idle_cpu_addr", 32'(mem_addr), 32'h3FF);
        fixed_addr = 0;

        // Stray done pulses, then conv_done coincident with conv_start
        strays = 1;
        lat[1] = 6;
        run_seq(200, ts, td);
        lat[1] = 0;
        run_seq(200, ts, td);
        check("early_done_run", 32'(td >= 0), 32'd1);
        lat[1] = 10;

        // Randomized latencies with random start and stray pulses
        rnd_start = 1;
        for (int r = 0; r < 20; r++) begin
            for (int s = 1; s <= 5; s++) lat[s] = int'($urandom_range(30));
            run_seq(400, ts, td);
        end
        rnd_start = 0; strays = 0;
        for (int i = 0; i < 8; i++) lat[i] = 10;
        run_cycle();

        // Watchdog: pool scheduler never answers in POOL0
        lat[2] = -1;
        tps = -1; te = -1; n = 0; start_req = 1'b1;
        while (n < 300 && te < 0) begin
            if (m_st != 0) start_req = 1'b0;
            run_cycle();
            n++;
            if (pool_start && tps < 0) tps = cyc;
            if (err && te < 0) te = cyc;
        end
        start_req = 1'b0;
        check("wdog_reached", 32'(te >= 0), 32'd1);
        check("wdog_latency", 32'(te - tps), 32'(LIMIT + 1));
        check("err_stage_pool0", 32'(err_stage), 32'd2);
        start_req = 1'b1;
        repeat (5) run_cycle();
        check("err_ignores_start", 32'(busy), 32'd0);
        start_req = 1'b0; clr_req = 1'b1;
        run_cycle();
        clr_req = 1'b0;
        check("err_cleared", 32'(err), 32'd0);
        run_cycle();
        lat[2] = 10;

        // fc_done exactly at the watchdog limit
        lat[5] = LIMIT;
        run_seq(300, ts, td);
        check("collision_done", 32'(td >= 0), 32'd1);
        check("collision_no_err", 32'(err), 32'd0);
        lat[5] = 10;

        // Reset during CONV1, then a fresh full run
        start_req = 1'b1; n = 0;
        while (n < 200 && !(m_st == 3 && m_age == 3)) begin
            if (m_st != 0) start_req = 1'b0;
            run_cycle();
            n++;
        end
        start_req = 1'b0;
        check("reach_conv1", 32'(conv_mode), 32'd1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        repeat (2) run_cycle();
        rst_n = 1'b1;
        run_seq(200, ts, td);
        check("rerun_latency", 32'(td - ts), 32'(1 + 5 * 11));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
